// File: rtl/fadd_normalize.sv
// Purpose : normalize and pack the raw mantissa sum of the FP adder into an IEEE-754 single.
// Latency : input accepted at edge 0, out_valid high after edge k+1 (k = left shifts, 0..23).
// Backpressure: result/out_valid held in DONE until out_ready; in_ready only in IDLE (no bypass).
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake for intmdt_sum, exp_in, sign_a, sign_b, xor_in
//   intmdt_sum[24:0]      raw mantissa result (two's complement when xor_in=1)
//   exp_in[7:0]           common (larger) exponent
//   sign_a, sign_b        operand signs (a has the larger exponent)
//   xor_in                1 = mantissas were subtracted (a-b)
//   out_valid / out_ready downstream handshake for result
//   result[31:0]          packed float {sign, exp, frac}
module fadd_normalize (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] intmdt_sum,
    input  logic [7:0]  exp_in,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic        xor_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [24:0] mag_q;
    logic [7:0]  exp_q;
    logic        sign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= 25'd0;
            exp_q   <= 8'd0;
            sign_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // A negative difference means b was the larger magnitude:
                        // take the magnitude and inherit b's sign.
                        if (xor_in && intmdt_sum[24]) begin
                            mag_q  <= -intmdt_sum;
                            sign_q <= sign_b;
                        end else begin
                            mag_q  <= intmdt_sum;
                            sign_q <= sign_a;
                        end
                        exp_q   <= exp_in;
                        state_q <= NORM;
                    end
                end

                NORM: begin
                    if (exp_q == 8'hFF) begin
                        // NaN/Inf operand: pass through untouched.
                        state_q <= DONE;
                    end else if (mag_q == 25'd0) begin
                        // Exact cancellation always yields +0.
                        sign_q  <= 1'b0;
                        exp_q   <= 8'd0;
                        state_q <= DONE;
                    end else if (mag_q[24]) begin
                        // Carry out of the add: one right shift, possibly overflowing to Inf.
                        if (exp_q == 8'hFE) begin
                            exp_q <= 8'hFF;
                            mag_q <= 25'd0;
                        end else begin
                            exp_q <= exp_q + 8'd1;
                            mag_q <= mag_q >> 1;
                        end
                        state_q <= DONE;
                    end else if (mag_q[23]) begin
                        state_q <= DONE;
                    end else if (exp_q <= 8'd1) begin
                        // Ran out of exponent range: result is subnormal, exp field 0.
                        exp_q   <= 8'd0;
                        state_q <= DONE;
                    end else begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 8'd1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs come straight from registers so they are glitch-free and
    // stable while the result waits for out_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = {sign_q, exp_q, mag_q[22:0]};

endmodule

// File: tb/tb_fadd_normalize.sv
module tb_fadd_normalize;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] intmdt_sum;
    logic [7:0]  exp_in;
    logic        sign_a;
    logic        sign_b;
    logic        xor_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int n_cmp;
    int n_err;

    fadd_normalize dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .intmdt_sum (intmdt_sum),
        .exp_in     (exp_in),
        .sign_a     (sign_a),
        .sign_b     (sign_b),
        .xor_in     (xor_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: treat the sum as an integer magnitude, find its leading one,
    // and decide the final exponent/fraction arithmetically.
    function automatic void model(input logic [24:0] sum, input logic [7:0] e,
                                  input logic sa, input logic sb, input logic x,
                                  output logic [31:0] res, output int k);
        int m, ee, msb, need, avail;
        logic s;
        logic [24:0] mm;
        k = 0;
        if (x && sum[24]) begin
            m = 33554432 - int'(sum);
            s = sb;
        end else begin
            m = int'(sum);
            s = sa;
        end
        ee = int'(e);
        if (ee == 255) begin
            mm  = m[24:0];
            res = {s, 8'hFF, mm[22:0]};
        end else if (m == 0) begin
            res = 32'd0;
        end else if (m >= 16777216) begin
            ee = ee + 1;
            m  = m / 2;
            mm = m[24:0];
            if (ee == 255) res = {s, 8'hFF, 23'd0};
            else           res = {s, ee[7:0], mm[22:0]};
        end else begin
            msb = 0;
            for (int i = 0; i < 25; i++) if (m >= (1 << i)) msb = i;
            need  = 23 - msb;
            avail = (ee > 1) ? ee - 1 : 0;
            k     = (need < avail) ? need : avail;
            m     = m << k;
            ee    = ee - k;
            mm    = m[24:0];
            if (k < need) res = {s, 8'd0, mm[22:0]};
            else          res = {s, ee[7:0], mm[22:0]};
        end
    endfunction

    // Drive one operation and wait (bounded) for out_valid; lat counts edges after capture.
    task automatic run_op(input logic [24:0] sum, input logic [7:0] e,
                          input logic sa, input logic sb, input logic x,
                          output logic [31:0] res, output int lat, output bit to);
        @(negedge clk);
        intmdt_sum = sum;
        exp_in     = e;
        sign_a     = sa;
        sign_b     = sb;
        xor_in     = x;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        to  = !out_valid;
        res = result;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
            n_err++;
            $display("FAIL reset: in_ready=%b out_valid=%b result=%h, required 1 0 00000000",
                     in_ready, out_valid, result);
        end
    endtask

    typedef struct {
        logic [24:0] sum;
        logic [7:0]  e;
        logic        sa, sb, x;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[6];
        logic [31:0] r;
        int lat;
        bit to;
        v[0] = '{25'h1800000, 8'd127, 1'b0, 1'b0, 1'b0, 32'h40400000, 1};
        v[1] = '{25'h0200000, 8'd127, 1'b0, 1'b1, 1'b1, 32'h3E800000, 3};
        v[2] = '{25'h1E00000, 8'd127, 1'b0, 1'b1, 1'b1, 32'hBE800000, 3};
        v[3] = '{25'h0000000, 8'd127, 1'b1, 1'b1, 1'b1, 32'h00000000, 1};
        v[4] = '{25'h1FFFFFE, 8'd254, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1};
        v[5] = '{25'h0000400, 8'd3,   1'b0, 1'b0, 1'b0, 32'h00001000, 3};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].sum, v[i].e, v[i].sa, v[i].sb, v[i].x, r, lat, to);
            n_cmp++;
            if (to) begin
                n_err++;
                $display("FAIL directed%0d timeout: out_valid never rose, required after edge %0d",
                         i, v[i].exp_lat);
            end else begin
                if (r !== v[i].exp_res) begin
                    n_err++;
                    $display("FAIL directed%0d result: got %h, required %h", i, r, v[i].exp_res);
                end
                n_cmp++;
                if (lat !== v[i].exp_lat) begin
                    n_err++;
                    $display("FAIL directed%0d latency: got %0d, required %0d", i, lat, v[i].exp_lat);
                end
            end
            accept();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d release: in_ready=%b out_valid=%b, required 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [24:0] sum;
        logic [7:0]  e;
        logic        sa, sb, x;
        logic [31:0] r, er;
        int lat, k, sel;
        bit to;
        for (int i = 0; i < 250; i++) begin
            sum = 25'($urandom) >> $urandom_range(0, 24);
            sel = $urandom_range(0, 9);
            if (sel == 0)      e = 8'hFF;
            else if (sel == 1) e = 8'hFE;
            else if (sel == 2) e = 8'($urandom_range(0, 3));
            else               e = 8'($urandom_range(0, 255));
            sa = 1'($urandom);
            sb = 1'($urandom);
            x  = 1'($urandom);
            model(sum, e, sa, sb, x, er, k);
            run_op(sum, e, sa, sb, x, r, lat, to);
            n_cmp++;
            if (to || r !== er || lat !== k + 1) begin
                n_err++;
                $display("FAIL random%0d sum=%h exp=%0d x=%b: got %h lat %0d to %0b, required %h lat %0d",
                         i, sum, e, x, r, lat, to, er, k + 1);
            end
            accept();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, er;
        int lat, k;
        bit to;
        run_op(25'h1800000, 8'd127, 1'b0, 1'b0, 1'b0, r, lat, to);
        // Offer a competing input throughout DONE; it must be ignored.
        @(negedge clk);
        intmdt_sum = 25'h0200000;
        exp_in     = 8'd127;
        sign_a     = 1'b0;
        sign_b     = 1'b1;
        xor_in     = 1'b1;
        in_valid   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (result !== 32'h40400000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure cycle%0d: result=%h out_valid=%b in_ready=%b, required 40400000 1 0",
                         c, result, out_valid, in_ready);
            end
        end
        accept();
        // The accepting edge must not have captured the pending input.
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL no_bypass: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        model(25'h0200000, 8'd127, 1'b0, 1'b1, 1'b1, er, k);
        n_cmp++;
        if (!out_valid || result !== er || lat !== k + 1) begin
            n_err++;
            $display("FAIL after_backpressure: got %h lat %0d, required %h lat %0d",
                     result, lat, er, k + 1);
        end
        accept();
    endtask

    task automatic test_reset_async();
        logic [31:0] r;
        int lat;
        bit to;
        // Mid-NORM: the 0x400 case needs two shifts, so one edge after capture is still NORM.
        @(negedge clk);
        intmdt_sum = 25'h0000400;
        exp_in     = 8'd3;
        sign_a     = 1'b0;
        sign_b     = 1'b0;
        xor_in     = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_norm: out_valid=%b in_ready=%b result=%h, required 0 1 00000000",
                     out_valid, in_ready, result);
        end
        @(negedge clk);
        rst = 1'b0;
        // In DONE with a pending result.
        run_op(25'h1800000, 8'd127, 1'b0, 1'b0, 1'b0, r, lat, to);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_done: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int lat;
        bit to;
        for (int i = 0; i < 2; i++) begin
            run_op(25'h1800000, 8'd127, 1'b0, 1'b0, 1'b0, r, lat, to);
            n_cmp++;
            if (to || r !== 32'h40400000 || lat !== 1) begin
                n_err++;
                $display("FAIL back_to_back%0d: got %h lat %0d, required 40400000 lat 1", i, r, lat);
            end
            accept();
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        intmdt_sum = 25'd0;
        exp_in     = 8'd0;
        sign_a     = 1'b0;
        sign_b     = 1'b0;
        xor_in     = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_directed();
        test_backpressure();
        test_reset_async();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
